encode8_3_scan: RTL and testbench
=================================

ENCODE8_3_SCAN -- requirements
Module: encode8_3_scan

Interface
REQ-001 Parameter SKIP_ZERO, default 0; when 1, an all-zero input vector is consumed without producing any output beat.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_vec is valid.
REQ-005 in_ready  output  1  block can accept in_vec this cycle.
REQ-006 in_vec  input  8  request vector; each set bit is one code to emit.
REQ-007 out_valid  output  1  out_code, out_last and out_none are valid.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 out_code  output  3  binary index of the current set bit.
REQ-010 out_last  output  1  current beat is the final beat for the captured vector.
REQ-011 out_none  output  1  captured vector was all-zero; out_code is 3'b000.

Function
REQ-012 States SHALL be IDLE and EMIT; in_ready SHALL be 1 only in IDLE.
REQ-013 Input transfer occurs when in_valid and in_ready are both 1; in_vec SHALL then be captured into an 8-bit pending register.
REQ-014 On a nonzero capture, the state SHALL go to EMIT and out_valid SHALL rise on the following cycle; latency from capture to first beat is 1 cycle.
REQ-015 In EMIT, out_code SHALL be the index of the lowest set pending bit; out_last SHALL be 1 iff exactly one pending bit remains.
REQ-016 Output transfer occurs when out_valid and out_ready are both 1; that bit SHALL then be cleared from pending.
REQ-017 On a transfer with out_last=1, the state SHALL return to IDLE; in_ready SHALL be 1 in the next cycle, so throughput is popcount(in_vec)+1 cycles per vector.
REQ-018 With out_valid=1 and out_ready=0, out_code, out_last and out_none SHALL hold stable.
REQ-019 All-zero capture with SKIP_ZERO=0: the block SHALL emit exactly one beat with out_none=1, out_last=1 and out_code=3'b000.
REQ-020 All-zero capture with SKIP_ZERO=1: the block SHALL stay in IDLE with in_ready=1 and produce no beat.
REQ-021 in_vec=8'hFF SHALL produce 8 beats with codes 0..7; only the eighth beat SHALL have out_last=1.
REQ-022 out_none SHALL be 0 on every beat of a nonzero vector.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately force IDLE, pending=0, out_valid=0, out_code=0, out_last=0, out_none=0 and in_ready=0.
REQ-024 in_ready SHALL become 1 on the first rising clk after rst_n deasserts.
REQ-025 A reset asserted mid-EMIT SHALL discard the remaining pending bits, and no further beats of that vector SHALL appear.

Configuration
REQ-026 Macro ENC_MSB_FIRST_EN: when defined, the scan order SHALL be highest set bit first (8'h81 -> codes 7, then 0).
REQ-027 When ENC_MSB_FIRST_EN is not defined, the scan order SHALL be lowest set bit first (8'h81 -> codes 0, then 7).
REQ-028 ENC_MSB_FIRST_EN SHALL NOT change the out_last, out_none or handshake behaviour.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, EMIT) and the constants VEC_W=8 and CODE_W=3.
REQ-030 The combinational priority encoder (pending vector -> code, single-bit flag) SHALL be a sub-module named prio_enc8_3, instantiated once.
REQ-031 The scan-order macro SHALL be applied inside prio_enc8_3.

Verification
REQ-032 in_vec=8'b0010_0101, out_ready=1 -> codes 0, 2, 5; out_last only on code 5; in_ready returns 1 cycle after the final beat.
REQ-033 in_vec=8'h00 with SKIP_ZERO=0 -> one beat: code 0, out_none=1, out_last=1. With SKIP_ZERO=1 -> no beat and in_ready stays 1.
REQ-034 in_vec=8'hFF with out_ready toggling 1,0,1,0 -> codes 0..7 in order, outputs held stable while stalled, no beat lost or duplicated.
REQ-035 in_vec=8'h81 with ENC_MSB_FIRST_EN defined -> codes 7, then 0. Without it -> codes 0, then 7.
REQ-036 rst_n pulsed low after 2 of 4 beats of 8'h0F -> out_valid falls asynchronously, and after release the next vector 8'h10 yields only code 4.

Source files
------------

// File: rtl/encode8_3_scan_pkg.sv
// rtl/encode8_3_scan_pkg.sv - shared types and constants for the 8-to-3 scanning encoder
package encode8_3_scan_pkg;

    localparam int VEC_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/encode8_3_scan_prio_enc8_3.sv
// rtl/encode8_3_scan_prio_enc8_3.sv - combinational priority encoder, scan order set by ENC_MSB_FIRST_EN
module prio_enc8_3
    import encode8_3_scan_pkg::*;
(
    input  logic [VEC_W-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic              single
);

    // Pick the first set bit in scan order; an all-zero vector encodes to 0.
    always_comb begin
        code = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < VEC_W; i++) begin
            if (vec[i]) code = CODE_W'(i);
        end
`else
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) code = CODE_W'(i);
        end
`endif
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign single = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);

endmodule

// File: rtl/encode8_3_scan.sv
// rtl/encode8_3_scan.sv - scans a captured 8-bit request vector and emits one code per set bit (ENC_MSB_FIRST_EN selects order)
module encode8_3_scan
    import encode8_3_scan_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_none
);

    state_t             state;
    logic [VEC_W-1:0]   pending;
    logic               none_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CODE_W-1:0]  enc_code;
    logic               enc_single;
    logic [VEC_W-1:0]   clear_mask;

    prio_enc8_3 u_prio_enc (
        .vec    (pending),
        .code   (enc_code),
        .single (enc_single)
    );

    // Outputs come straight from registered state, so they hold while stalled.
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_code   = enc_code;
    assign out_none   = none_q;
    assign out_last   = out_valid_q & (none_q | enc_single);
    assign clear_mask = VEC_W'(1) << enc_code;

    // Capture in IDLE, then retire one pending bit per accepted beat in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            none_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        pending <= in_vec;
                        if (in_vec != '0) begin
                            state       <= EMIT;
                            none_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else if (!SKIP_ZERO) begin
                            state       <= EMIT;
                            none_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending <= pending & ~clear_mask;
                        if (out_last) begin
                            state       <= IDLE;
                            none_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    pending     <= '0;
                    none_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encode8_3_scan.sv
// tb/tb_encode8_3_scan.sv - randomized self-checking bench for encode8_3_scan (honours ENC_MSB_FIRST_EN)
module tb_encode8_3_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_vec = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_code;
    logic       out_last;
    logic       out_none;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_vec = 8'h00;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    logic [2:0] s_out_code;
    logic       s_out_last;
    logic       s_out_none;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encode8_3_scan #(.SKIP_ZERO(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    encode8_3_scan #(.SKIP_ZERO(1'b1)) dut_skip (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_vec    (s_in_vec),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_code  (s_out_code),
        .out_last  (s_out_last),
        .out_none  (s_out_none)
    );

    // Sends one vector and checks every beat against the expected code list.
    // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready.
    task automatic run_vector(input logic [7:0] v, input int mode);
        logic [2:0] exp_code[$];
        logic       zero;
        logic       rdy;
        logic       exp_last;
        int         n;
        int         idx;
        int         guard;
        exp_code = {};
        zero = (v == 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
                exp_code.push_front(3'(i));
`else
                exp_code.push_back(3'(i));
`endif
            end
        end
        if (zero) exp_code.push_back(3'd0);
        n = exp_code.size();

        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait vec=%h got=%b exp=1", v, in_ready);
        end

        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 8'($urandom);

        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency vec=%h out_valid got=%b exp=1", v, out_valid);
        end

        idx = 0;
        guard = 0;
        while (idx < n && guard < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            exp_last = (idx == n - 1);
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code[idx] ||
                out_last !== exp_last || out_none !== zero) begin
                errors++;
                $display("FAIL beat vec=%h idx=%0d got v=%b c=%0d l=%b n=%b exp v=1 c=%0d l=%b n=%b",
                         v, idx, out_valid, out_code, out_last, out_none,
                         exp_code[idx], exp_last, zero);
            end
            if (rdy) idx++;
            guard++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL beat_budget vec=%h got=%0d beats exp=%0d", v, idx, n);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_state vec=%h got in_ready=%b out_valid=%b exp 1/0", v, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 3'd0 ||
            out_last !== 1'b0 || out_none !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got v=%b r=%b c=%0d l=%b n=%b exp all 0",
                     out_valid, in_ready, out_code, out_last, out_none);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got=%b exp=0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got=%b/%b exp=1/1", in_ready, s_in_ready);
        end
    endtask

    task automatic test_basic();
        run_vector(8'b0010_0101, 0);
    endtask

    task automatic test_zero();
        run_vector(8'h00, 0);
    endtask

    task automatic test_order();
        run_vector(8'h81, 0);
    endtask

    task automatic test_stall_ff();
        run_vector(8'hFF, 1);
    endtask

    task automatic test_skip_zero();
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_vec    = 8'h00;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL skip_zero cyc=%0d got out_valid=%b in_ready=%b exp 0/1", k, s_out_valid, s_in_ready);
            end
            @(posedge clk); #1;
        end
        s_in_valid = 1'b1;
        s_in_vec   = 8'h04;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_code !== 3'd2 || s_out_last !== 1'b1 || s_out_none !== 1'b0) begin
            errors++;
            $display("FAIL skip_nonzero got v=%b c=%0d l=%b n=%b exp 1/2/1/0", s_out_valid, s_out_code, s_out_last, s_out_none);
        end
        @(posedge clk); #1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skip_done got in_ready=%b out_valid=%b exp 1/0", s_in_ready, s_out_valid);
        end
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 8'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_emit_pre got out_valid=%b out_last=%b exp 1/0", out_valid, out_last);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 3'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b r=%b c=%0d l=%b exp 0/0/0/0", out_valid, in_ready, out_code, out_last);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_beat got out_valid=%b exp=0", out_valid);
        end
        run_vector(8'h10, 0);
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int k = 0; k < 40; k++) begin
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_vector(v, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        run_vector(8'h80, 0);
        run_vector(8'h01, 2);
        run_vector(8'h00, 1);
        run_vector(8'h7E, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_order();
        test_stall_ff();
        test_skip_zero();
        test_reset_mid_emit();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
